// File: rtl/fpcvt_pkg.sv
// Shared constants and segment encoding for the converter display stage.
package fpcvt_pkg;

    localparam int EXP_W = 3;
    localparam int SIG_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [1:0] DIG_SIGN  = 2'd3;
    localparam logic [1:0] DIG_EXP   = 2'd2;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_UNITS = 2'd0;

    // Active-low segment pattern, bit order g..a; anything outside 0-9 is blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/fpcvt_display_if.sv
// Converter-side capture inputs and board-side display outputs of the display stage.
interface fpcvt_display_if;
    import fpcvt_pkg::*;

    logic             load;
    logic             S;
    logic [EXP_W-1:0] E;
    logic [SIG_W-1:0] F;
    logic [6:0]       seg;
    logic             dp;
    logic [3:0]       an;
    logic             valid;

    modport master (output load, S, E, F, input seg, dp, an, valid);
    modport slave  (input load, S, E, F, output seg, dp, an, valid);

endinterface

// File: rtl/fpcvt_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module seg7_decode
    import fpcvt_pkg::*;
(
    input  logic [3:0] val,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_s;

    // Blank request or non-decimal value forces all segments off
    always_comb begin
        seg_s = SEG_BLANK;
        if (blank || (val > 4'd9)) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_encode(val);
        end
    end

    assign seg = seg_s;

endmodule

// File: rtl/fpcvt_display.sv
// Captures the converter's S/E/F word and scans it onto a 4-digit active-low
// seven-segment display: sign, exponent with decimal point, significand tens, units.
module fpcvt_display
    import fpcvt_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    fpcvt_display_if.slave    bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);

    logic             s_r;
    logic [EXP_W-1:0] e_r;
    logic [SIG_W-1:0] f_r;
    logic             valid_r;
    logic [PW-1:0]    pcnt_r;
    logic [1:0]       idx_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic [3:0]       an_r;

    logic             tick_s;
    logic [1:0]       nidx_s;
    logic             tens_s;
    logic [SIG_W-1:0] units_s;
    logic [3:0]       dec_val_s;
    logic             dec_blank_s;
    logic [6:0]       dec_seg_s;
    logic             minus_s;
    logic [6:0]       seg_nxt_s;
    logic             dp_nxt_s;
    logic [3:0]       an_nxt_s;

    assign tick_s  = (pcnt_r == PCNT_LAST);
    assign nidx_s  = idx_r + 2'd1;
    assign tens_s  = (f_r >= 4'd10);
    assign units_s = tens_s ? (f_r - 4'd10) : f_r;
    assign an_nxt_s = ~(4'b0001 << nidx_s);

    // Capture register; reset wins over a coincident load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_r     <= 1'b0;
            e_r     <= {EXP_W{1'b0}};
            f_r     <= {SIG_W{1'b0}};
            valid_r <= 1'b0;
        end else if (bus.load) begin
            s_r     <= bus.S;
            e_r     <= bus.E;
            f_r     <= bus.F;
            valid_r <= 1'b1;
        end
    end

    // Slot prescaler and digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_r <= {PW{1'b0}};
            idx_r  <= 2'd0;
        end else if (tick_s) begin
            pcnt_r <= {PW{1'b0}};
            idx_r  <= nidx_s;
        end else begin
            pcnt_r <= pcnt_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Select what the upcoming slot shows, from the capture register as it stands now
    always_comb begin
        dec_val_s   = 4'd0;
        dec_blank_s = 1'b1;
        minus_s     = 1'b0;
        dp_nxt_s    = 1'b1;
        seg_nxt_s   = SEG_BLANK;
        case (nidx_s)
            DIG_SIGN: begin
                minus_s = s_r;
            end
            DIG_EXP: begin
                dec_val_s   = {{(SIG_W-EXP_W){1'b0}}, e_r};
                dec_blank_s = 1'b0;
                dp_nxt_s    = 1'b0;
            end
            DIG_TENS: begin
                dec_val_s   = 4'd1;
                dec_blank_s = ~tens_s;
            end
            DIG_UNITS: begin
                dec_val_s   = units_s;
                dec_blank_s = 1'b0;
            end
            default: begin
                dec_blank_s = 1'b1;
            end
        endcase
        if (!valid_r) begin
            seg_nxt_s = SEG_BLANK;
            dp_nxt_s  = 1'b1;
        end else if (minus_s) begin
            seg_nxt_s = SEG_MINUS;
        end else begin
            seg_nxt_s = dec_seg_s;
        end
    end

    seg7_decode u_dec (
        .val   (dec_val_s),
        .blank (dec_blank_s),
        .seg   (dec_seg_s)
    );

    // Display outputs change only on a slot boundary, so they are glitch-free per slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_r  <= 4'b1110;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else if (tick_s) begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            dp_r  <= dp_nxt_s;
        end
    end

    assign bus.seg   = seg_r;
    assign bus.dp    = dp_r;
    assign bus.an    = an_r;
    assign bus.valid = valid_r;

endmodule
